// File: rtl/edge_detect_pkg.sv
// Shared FSM encoding and matrix geometry for the frame buffer scan path.
// Pure declarations; no timing or flow control of its own.
package edge_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_PRESENT,
    ST_DONE
  } scan_state_t;

  // Eight neighbours around the centre pixel: TL,T,TR,ML,MR,BL,B,BR.
  localparam int unsigned MATRIX_TAPS = 8;

  function automatic int unsigned matrix_width(input int unsigned depth);
    return MATRIX_TAPS * depth;
  endfunction

endpackage

// File: rtl/frame_buffer_scan_controller_raster_counter.sv
// Column/row raster position with clear, advance and explicit wrap; last flags (P_ROWS-1,P_COLUMNS-1).
// Updates one cycle after clear/advance; clear has priority, no backpressure.
module raster_counter #(
  parameter int P_COLUMNS = 640,
  parameter int P_ROWS = 4,
  localparam int CW = $clog2(P_COLUMNS),
  localparam int RW = $clog2(P_ROWS)
) (
  input  logic          I_CLK,
  input  logic          I_RESET_N,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] column,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_LAST = CW'(P_COLUMNS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(P_ROWS - 1);

  logic col_last;
  logic row_last;

  assign col_last = (column == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign last     = col_last && row_last;

  // Compare-and-wrap rather than relying on natural overflow, so non power-of-2 sizes work.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      column <= '0;
      row    <= '0;
    end else if (clear) begin
      column <= '0;
      row    <= '0;
    end else if (advance) begin
      if (col_last) begin
        column <= '0;
        row    <= row_last ? '0 : row + 1'b1;
      end else begin
        column <= column + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_scan_controller.sv
// Fills the 3x3 frame buffer from a raster pixel stream, then scans it issuing one read per position.
// Writes land on the handshake edge; each matrix appears one cycle after its read and holds until I_MATRIX_READY.
module frame_buffer_scan_controller
  import edge_detect_pkg::*;
#(
  parameter int P_COLUMNS = 640,
  parameter int P_ROWS = 4,
  parameter int P_PIXEL_DEPTH = 8,
  localparam int P_COLUMNS_BIT_COUNT = $clog2(P_COLUMNS),
  localparam int P_ROWS_BIT_COUNT = $clog2(P_ROWS),
  localparam int P_O_PIXEL_MATRIX_BIT_COUNT = matrix_width(P_PIXEL_DEPTH)
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RESET_N,
  input  logic                                  I_START,
  input  logic                                  I_PIXEL_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]              I_PIXEL,
  output logic                                  O_PIXEL_READY,
  output logic [P_COLUMNS_BIT_COUNT-1:0]        O_BUF_COLUMN,
  output logic [P_ROWS_BIT_COUNT-1:0]           O_BUF_ROW,
  output logic [P_PIXEL_DEPTH-1:0]              O_BUF_PIXEL,
  output logic                                  O_BUF_WRITE_ENABLE,
  output logic                                  O_BUF_READ_ENABLE,
  input  logic [P_O_PIXEL_MATRIX_BIT_COUNT-1:0] I_BUF_PIXEL_MATRIX,
  output logic [P_O_PIXEL_MATRIX_BIT_COUNT-1:0] O_MATRIX,
  output logic                                  O_MATRIX_VALID,
  input  logic                                  I_MATRIX_READY,
  output logic [P_ROWS_BIT_COUNT-1:0]           O_MATRIX_ROW,
  output logic [P_COLUMNS_BIT_COUNT-1:0]        O_MATRIX_COLUMN,
  output logic                                  O_FRAME_DONE,
  output logic                                  O_BUSY
);

  scan_state_t state;
  scan_state_t state_nxt;

  logic                           cnt_clear;
  logic                           cnt_advance;
  logic                           cnt_last;
  logic [P_COLUMNS_BIT_COUNT-1:0] cnt_column;
  logic [P_ROWS_BIT_COUNT-1:0]    cnt_row;

  // Fill and scan never overlap, so one position counter serves both phases.
  raster_counter #(
    .P_COLUMNS (P_COLUMNS),
    .P_ROWS    (P_ROWS)
  ) u_raster_counter (
    .I_CLK     (I_CLK),
    .I_RESET_N (I_RESET_N),
    .clear     (cnt_clear),
    .advance   (cnt_advance),
    .column    (cnt_column),
    .row       (cnt_row),
    .last      (cnt_last)
  );

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    cnt_clear          = 1'b0;
    cnt_advance        = 1'b0;
    O_PIXEL_READY      = 1'b0;
    O_BUF_WRITE_ENABLE = 1'b0;
    O_BUF_READ_ENABLE  = 1'b0;
    O_MATRIX_VALID     = 1'b0;
    O_FRAME_DONE       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (I_START) begin
          state_nxt = ST_FILL;
          cnt_clear = 1'b1;
        end
      end
      ST_FILL: begin
        O_PIXEL_READY = 1'b1;
        if (I_PIXEL_VALID) begin
          O_BUF_WRITE_ENABLE = 1'b1;
          if (cnt_last) begin
            state_nxt = ST_READ;
            cnt_clear = 1'b1;
          end else begin
            cnt_advance = 1'b1;
          end
        end
      end
      ST_READ: begin
        O_BUF_READ_ENABLE = 1'b1;
        state_nxt         = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Counter only moves on the handshake, keeping row/column stable while stalled.
        O_MATRIX_VALID = 1'b1;
        if (I_MATRIX_READY) begin
          if (cnt_last) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_advance = 1'b1;
            state_nxt   = ST_READ;
          end
        end
      end
      ST_DONE: begin
        O_FRAME_DONE = 1'b1;
        cnt_clear    = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign O_BUF_COLUMN    = cnt_column;
  assign O_BUF_ROW       = cnt_row;
  assign O_BUF_PIXEL     = O_PIXEL_READY ? I_PIXEL : '0;
  assign O_MATRIX        = I_BUF_PIXEL_MATRIX;
  assign O_MATRIX_ROW    = cnt_row;
  assign O_MATRIX_COLUMN = cnt_column;
  assign O_BUSY          = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_buffer_scan_controller.sv
// Directed bench for frame_buffer_scan_controller with a behavioural 3x3 frame buffer on a 4x3 frame.
module tb_frame_buffer_scan_controller;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pix_vld;
  logic [7:0]  pix;
  logic        pix_rdy;
  logic [1:0]  buf_col;
  logic [1:0]  buf_row;
  logic [7:0]  buf_pix;
  logic        buf_we;
  logic        buf_re;
  logic [63:0] buf_mat;
  logic [63:0] mat;
  logic        mat_vld;
  logic        mat_rdy;
  logic [1:0]  mat_row;
  logic [1:0]  mat_col;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_buffer_scan_controller #(
    .P_COLUMNS     (COLS),
    .P_ROWS        (ROWS),
    .P_PIXEL_DEPTH (8)
  ) dut (
    .I_CLK              (clk),
    .I_RESET_N          (rst_n),
    .I_START            (start),
    .I_PIXEL_VALID      (pix_vld),
    .I_PIXEL            (pix),
    .O_PIXEL_READY      (pix_rdy),
    .O_BUF_COLUMN       (buf_col),
    .O_BUF_ROW          (buf_row),
    .O_BUF_PIXEL        (buf_pix),
    .O_BUF_WRITE_ENABLE (buf_we),
    .O_BUF_READ_ENABLE  (buf_re),
    .I_BUF_PIXEL_MATRIX (buf_mat),
    .O_MATRIX           (mat),
    .O_MATRIX_VALID     (mat_vld),
    .I_MATRIX_READY     (mat_rdy),
    .O_MATRIX_ROW       (mat_row),
    .O_MATRIX_COLUMN    (mat_col),
    .O_FRAME_DONE       (frame_done),
    .O_BUSY             (busy)
  );

  // Behavioural frame buffer: zero-padded neighbourhood registered on read, held otherwise.
  logic [7:0] mem [ROWS][COLS];

  function automatic logic [7:0] mem_at(int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 8'h00;
    return mem[r][c];
  endfunction

  function automatic logic [63:0] mem_nb(int r, int c);
    return {mem_at(r-1, c-1), mem_at(r-1, c), mem_at(r-1, c+1), mem_at(r, c-1),
            mem_at(r, c+1), mem_at(r+1, c-1), mem_at(r+1, c), mem_at(r+1, c+1)};
  endfunction

  always @(posedge clk) begin
    if (buf_we && int'(buf_row) < ROWS) mem[buf_row][buf_col] <= buf_pix;
    if (buf_re) buf_mat <= mem_nb(int'(buf_row), int'(buf_col));
  end

  // Expected image content: pixel = row*16 + col, zero outside the frame.
  function automatic logic [7:0] px(int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 8'h00;
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [63:0] exp_mat(int r, int c);
    return {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1),
            px(r, c+1), px(r+1, c-1), px(r+1, c), px(r+1, c+1)};
  endfunction

  // Continuous protocol checker.
  logic prev_done = 1'b0;
  always begin
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      checks++;
      if (buf_we && buf_re) begin
        errors++;
        $display("FAIL we_re_exclusive: we=%b re=%b required not both 1", buf_we, buf_re);
      end
      if (frame_done && prev_done) begin
        errors++;
        $display("FAIL done_width: done high two consecutive cycles, required one");
      end
    end
    prev_done = frame_done;
  end

  // Results recorded by the frame driver, compared by the scenario tasks.
  logic [63:0] got_mat [N];
  int          got_row [N];
  int          got_col [N];
  int          wr_row  [N];
  int          wr_col  [N];
  logic [7:0]  wr_pix  [N];
  logic [63:0] st_mat  [5];
  int          st_row  [5];
  int          st_col  [5];
  logic        st_vld  [5];
  int          nmat, nwr, done_cyc, busy_cyc, gap_bad, gaps_seen;
  logic        ready_at_entry, post_done_busy, post_done_pulse;

  task automatic run_frame(input bit gaps, input int stall_idx, input bit pokes);
    int stall_cnt;
    stall_cnt = 0;
    nmat = 0; nwr = 0; done_cyc = -1; busy_cyc = 0; gap_bad = 0; gaps_seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ready_at_entry = pix_rdy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_cyc >= 0) begin
        post_done_busy  = busy;
        post_done_pulse = frame_done;
        break;
      end
      start   = pokes && (cyc == 3 || cyc == 13);
      pix_vld = 1'b0;
      mat_rdy = 1'b0;
      if (busy) busy_cyc++;
      if (frame_done) done_cyc = cyc;
      if (pix_rdy) begin
        pix_vld = gaps ? (cyc % 5 != 2 && $urandom_range(0, 3) != 0) : 1'b1;
        pix     = px(nwr / COLS, nwr % COLS);
        #1;
        if (!pix_vld) begin
          gaps_seen++;
          if (buf_we) gap_bad++;
        end else if (buf_we && nwr < N) begin
          wr_row[nwr] = int'(buf_row);
          wr_col[nwr] = int'(buf_col);
          wr_pix[nwr] = buf_pix;
          nwr++;
        end
      end
      if (mat_vld) begin
        if (nmat == stall_idx && stall_cnt < 5) begin
          st_mat[stall_cnt] = mat;
          st_row[stall_cnt] = int'(mat_row);
          st_col[stall_cnt] = int'(mat_col);
          st_vld[stall_cnt] = mat_vld;
          stall_cnt++;
        end else begin
          mat_rdy = 1'b1;
          if (nmat < N) begin
            got_mat[nmat] = mat;
            got_row[nmat] = int'(mat_row);
            got_col[nmat] = int'(mat_col);
          end
          nmat++;
        end
      end
    end
    start = 1'b0; pix_vld = 1'b0; mat_rdy = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: no frame done within 400 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_vld = 1'b0; pix = 8'h5A; mat_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_rdy, buf_we, buf_re, mat_vld, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {pix_rdy, buf_we, buf_re, mat_vld, frame_done, busy});
    end
    checks++;
    if ({buf_col, buf_row, buf_pix, mat_row, mat_col} !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0000", {buf_col, buf_row, buf_pix, mat_row, mat_col});
    end
    @(negedge clk); rst_n = 1'b1;
    // Partially fill with inverted pixels, then pull reset between clock edges.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_vld = 1'b1;
      pix     = px(i / COLS, i % COLS) ^ 8'hFF;
      @(negedge clk);
    end
    pix_vld = 1'b1; pix = 8'hA5;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_rdy, buf_we, buf_re, mat_vld, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_flags: got %b required 000000",
               {pix_rdy, buf_we, buf_re, mat_vld, frame_done, busy});
    end
    checks++;
    if ({buf_col, buf_row, buf_pix} !== 12'h0) begin
      errors++;
      $display("FAIL async_reset_addr: got %h required 000", {buf_col, buf_row, buf_pix});
    end
    @(negedge clk); rst_n = 1'b1; pix_vld = 1'b0;
    run_frame(1'b0, -1, 1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (mem[r][c] !== px(r, c)) begin
          errors++;
          $display("FAIL refill_mem(%0d,%0d): got %h required %h", r, c, mem[r][c], px(r, c));
        end
      end
  endtask

  task automatic test_full_frame();
    run_frame(1'b0, -1, 1'b0);
    checks++;
    if (ready_at_entry !== 1'b1) begin
      errors++;
      $display("FAIL fill_entry_ready: got %b required 1", ready_at_entry);
    end
    checks++;
    if (nwr != N || nmat != N) begin
      errors++;
      $display("FAIL full_counts: writes %0d matrices %0d required 12 12", nwr, nmat);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (wr_row[i] != i / COLS || wr_col[i] != i % COLS || wr_pix[i] !== px(i / COLS, i % COLS)) begin
        errors++;
        $display("FAIL write_%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", i, wr_row[i], wr_col[i],
                 wr_pix[i], i / COLS, i % COLS, px(i / COLS, i % COLS));
      end
      checks++;
      if (got_row[i] != i / COLS || got_col[i] != i % COLS || got_mat[i] !== exp_mat(i / COLS, i % COLS)) begin
        errors++;
        $display("FAIL matrix_%0d: got (%0d,%0d) %h required (%0d,%0d) %h", i, got_row[i], got_col[i],
                 got_mat[i], i / COLS, i % COLS, exp_mat(i / COLS, i % COLS));
      end
    end
    checks++;
    if (got_mat[0] !== 64'h00000000_01001011) begin
      errors++;
      $display("FAIL corner_00: got %h required 0000000001001011", got_mat[0]);
    end
    checks++;
    if (got_mat[5] !== 64'h00010210_12202122) begin
      errors++;
      $display("FAIL centre_11: got %h required 0001021012202122", got_mat[5]);
    end
    // 12 fill + 24 scan cycles, so DONE occupies cycle 36 counting FILL entry as 0.
    checks++;
    if (done_cyc != 36 || busy_cyc != 37) begin
      errors++;
      $display("FAIL done_timing: done cycle %0d busy %0d required 36 37", done_cyc, busy_cyc);
    end
    checks++;
    if (post_done_busy !== 1'b0 || post_done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL post_done_idle: busy %b done %b required 0 0", post_done_busy, post_done_pulse);
    end
  endtask

  task automatic test_valid_gaps();
    run_frame(1'b1, -1, 1'b0);
    checks++;
    if (gap_bad != 0 || nwr != N) begin
      errors++;
      $display("FAIL gap_writes: gap writes %0d writes %0d required 0 12", gap_bad, nwr);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (mem[r][c] !== px(r, c)) begin
          errors++;
          $display("FAIL gap_mem(%0d,%0d): got %h required %h", r, c, mem[r][c], px(r, c));
        end
      end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_mat[i] !== exp_mat(i / COLS, i % COLS)) begin
        errors++;
        $display("FAIL gap_matrix_%0d: got %h required %h", i, got_mat[i], exp_mat(i / COLS, i % COLS));
      end
    end
    checks++;
    if (done_cyc != 36 + gaps_seen) begin
      errors++;
      $display("FAIL gap_done_timing: got %0d required %0d", done_cyc, 36 + gaps_seen);
    end
  endtask

  task automatic test_ready_stall();
    run_frame(1'b0, 11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (st_vld[k] !== 1'b1 || st_mat[k] !== 64'h12130022_00000000 || st_row[k] != 2 || st_col[k] != 3) begin
        errors++;
        $display("FAIL stall_hold_%0d: vld %b mat %h pos (%0d,%0d) required 1 1213002200000000 (2,3)",
                 k, st_vld[k], st_mat[k], st_row[k], st_col[k]);
      end
    end
    checks++;
    if (nmat != N || got_mat[11] !== 64'h12130022_00000000 || done_cyc != 41) begin
      errors++;
      $display("FAIL stall_finish: matrices %0d last %h done %0d required 12 1213002200000000 41",
               nmat, got_mat[11], done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(1'b0, -1, 1'b1);
    checks++;
    if (nmat != N || nwr != N || done_cyc != 36) begin
      errors++;
      $display("FAIL start_ignored: matrices %0d writes %0d done %0d required 12 12 36", nmat, nwr, done_cyc);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_row[i] != i / COLS || got_col[i] != i % COLS || got_mat[i] !== exp_mat(i / COLS, i % COLS)) begin
        errors++;
        $display("FAIL start_matrix_%0d: got (%0d,%0d) %h required %h", i, got_row[i], got_col[i],
                 got_mat[i], exp_mat(i / COLS, i % COLS));
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, -1, 1'b0);
    checks++;
    if (nmat != N || done_cyc != 36 || got_mat[N-1] !== exp_mat(ROWS - 1, COLS - 1)) begin
      errors++;
      $display("FAIL back_to_back: matrices %0d done %0d last %h required 12 36 %h",
               nmat, done_cyc, got_mat[N-1], exp_mat(ROWS - 1, COLS - 1));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_valid_gaps();
    test_ready_stall();
    test_start_ignored();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
